// File: rtl/argmax_int8_stream.sv
// Streaming signed max/argmax reducer: one result per frame over valid/ready.
// Includes the gt_int_nbit signed greater-than core it compares with.

module gt_int_nbit #(
    parameter int WIDTH     = 8,
    parameter int IMPL_TYPE = 0
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             gt_o
);

    generate
        if (IMPL_TYPE == 0) begin : g_signed
            always_comb gt_o = $signed(a_i) > $signed(b_i);
        end else begin : g_offset
            // Flipping the sign bit maps two's complement onto offset binary.
            logic [WIDTH-1:0] a_off;
            logic [WIDTH-1:0] b_off;
            always_comb begin
                a_off = a_i ^ {1'b1, {(WIDTH-1){1'b0}}};
                b_off = b_i ^ {1'b1, {(WIDTH-1){1'b0}}};
                gt_o  = a_off > b_off;
            end
        end
    endgenerate

endmodule

module argmax_int8_stream #(
    parameter int WIDTH     = 8,
    parameter int IDX_WIDTH = 8,
    parameter int IMPL_TYPE = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_max,
    output logic [IDX_WIDTH-1:0] out_idx,
    output logic                 out_ovf
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     max_q, max_d;
    logic [IDX_WIDTH-1:0] idx_q, idx_d;
    logic [IDX_WIDTH-1:0] cnt_q, cnt_d;
    logic                 wrap_q, wrap_d;
    logic                 ovf_q, ovf_d;
    logic [WIDTH-1:0]     out_max_q, out_max_d;
    logic [IDX_WIDTH-1:0] out_idx_q, out_idx_d;
    logic                 out_ovf_q, out_ovf_d;

    logic                 accept;
    logic                 gt;
    logic [IDX_WIDTH-1:0] cnt_sat;

    gt_int_nbit #(
        .WIDTH    (WIDTH),
        .IMPL_TYPE(IMPL_TYPE)
    ) u_gt (
        .a_i (in_data),
        .b_i (max_q),
        .gt_o(gt)
    );

    assign in_ready  = rst_n && (state_q != DONE);
    assign out_valid = (state_q == DONE);
    assign out_max   = out_max_q;
    assign out_idx   = out_idx_q;
    assign out_ovf   = out_ovf_q;
    assign accept    = in_valid && in_ready;
    // wrap_q marks that the counter has passed the last representable index.
    assign cnt_sat   = wrap_q ? {IDX_WIDTH{1'b1}} : cnt_q;

    always_comb begin
        state_d   = state_q;
        max_d     = max_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        wrap_d    = wrap_q;
        ovf_d     = ovf_q;
        out_max_d = out_max_q;
        out_idx_d = out_idx_q;
        out_ovf_d = out_ovf_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    max_d   = in_data;
                    idx_d   = '0;
                    cnt_d   = IDX_WIDTH'(1);
                    wrap_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = in_last ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    if (gt) begin
                        max_d = in_data;
                        idx_d = cnt_sat;
                    end
                    ovf_d = ovf_q | wrap_q;
                    if (!wrap_q) begin
                        cnt_d = cnt_q + IDX_WIDTH'(1);
                        if (&cnt_q) wrap_d = 1'b1;
                    end
                    if (in_last) state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (accept && in_last) begin
            out_max_d = max_d;
            out_idx_d = idx_d;
            out_ovf_d = ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            max_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            wrap_q    <= 1'b0;
            ovf_q     <= 1'b0;
            out_max_q <= '0;
            out_idx_q <= '0;
            out_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            max_q     <= max_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            wrap_q    <= wrap_d;
            ovf_q     <= ovf_d;
            out_max_q <= out_max_d;
            out_idx_q <= out_idx_d;
            out_ovf_q <= out_ovf_d;
        end
    end

endmodule

// File: tb/tb_argmax_int8_stream.sv
// Scoreboard bench for argmax_int8_stream: an 8-bit-index and a
// 2-bit-index instance share one input stream.

module tb_argmax_int8_stream;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic       in_ready2;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_valid2;
    logic       out_ready;
    logic [7:0] out_max;
    logic [7:0] out_max2;
    logic [7:0] out_idx;
    logic [1:0] out_idx2;
    logic       out_ovf;
    logic       out_ovf2;

    typedef struct {
        logic [7:0] mx;
        logic [7:0] i8;
        logic       o8;
        logic [1:0] i2;
        logic       o2;
    } exp_t;

    exp_t                  sb[$];
    logic signed [7:0]     frame[$];
    int                    vectors = 0;
    int                    errors  = 0;

    argmax_int8_stream #(.WIDTH(8), .IDX_WIDTH(8), .IMPL_TYPE(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_max(out_max), .out_idx(out_idx), .out_ovf(out_ovf)
    );

    argmax_int8_stream #(.WIDTH(8), .IDX_WIDTH(2), .IMPL_TYPE(1)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_max(out_max2), .out_idx(out_idx2), .out_ovf(out_ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expected();
        exp_t e;
        logic signed [7:0] m;
        int idx;
        m   = frame[0];
        idx = 0;
        for (int i = 1; i < frame.size(); i++) begin
            if (frame[i] > m) begin
                m   = frame[i];
                idx = i;
            end
        end
        e.mx = m;
        e.i8 = (idx > 255) ? 8'hFF : 8'(idx);
        e.o8 = (frame.size() > 256);
        e.i2 = (idx > 3) ? 2'd3 : 2'(idx);
        e.o2 = (frame.size() > 4);
        sb.push_back(e);
    endtask

    task automatic wait_accept();
        logic acc;
        int t;
        t = 0;
        do begin
            acc = in_ready;
            step();
            t++;
        end while (!acc && t < 50);
        vectors++;
        if (!acc) begin
            errors++;
            $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic check_result();
        exp_t e;
        vectors++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: out_max=%h", out_max);
            return;
        end
        e = sb.pop_front();
        vectors += 5;
        if (out_max !== e.mx || out_max2 !== e.mx) begin
            errors++;
            $display("FAIL out_max: got %h/%h required %h", out_max, out_max2, e.mx);
        end
        if (out_idx !== e.i8) begin
            errors++;
            $display("FAIL out_idx: got %0d required %0d", out_idx, e.i8);
        end
        if (out_ovf !== e.o8) begin
            errors++;
            $display("FAIL out_ovf: got %b required %b", out_ovf, e.o8);
        end
        if (out_idx2 !== e.i2) begin
            errors++;
            $display("FAIL out_idx2: got %0d required %0d", out_idx2, e.i2);
        end
        if (out_ovf2 !== e.o2) begin
            errors++;
            $display("FAIL out_ovf2: got %b required %b", out_ovf2, e.o2);
        end
    endtask

    task automatic run_frame(input bit do_hs, input int gap_at, input int gap_len);
        push_expected();
        out_ready = do_hs;
        for (int k = 0; k < frame.size(); k++) begin
            if (k == gap_at) begin
                in_valid = 1'b0;
                repeat (gap_len) step();
                vectors++;
                if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL gap_hold: out_valid=%b in_ready=%b required 0/1",
                             out_valid, in_ready);
                end
            end
            in_valid = 1'b1;
            in_data  = frame[k];
            in_last  = (k == frame.size() - 1);
            wait_accept();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_valid2 !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL latency: out_valid=%b/%b in_ready=%b required 1/1/0",
                     out_valid, out_valid2, in_ready);
        end
        if (do_hs) begin
            check_result();
            step();
            vectors++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL return_idle: out_valid=%b in_ready=%b required 0/1",
                         out_valid, in_ready);
            end
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) step();
        vectors++;
        if (out_valid !== 1'b0 || out_max !== 8'h00 || out_idx !== 8'h00 ||
            out_ovf !== 1'b0 || in_ready !== 1'b0 || in_ready2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: v=%b max=%h idx=%h ovf=%b rdy=%b required 0/00/00/0/0",
                     out_valid, out_max, out_idx, out_ovf, in_ready);
        end
        rst_n = 1'b1;
        step();
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_signed_frames();
        frame = {8'sd5, -8'sd3, 8'sd127, -8'sd128, 8'sd127};
        run_frame(1, -1, 0);
        frame = {-8'sd1, -8'sd128, -8'sd2};
        run_frame(1, -1, 0);
        frame = {-8'sd128};
        run_frame(1, -1, 0);
        frame = {8'sd0, 8'sd0, 8'sd1, -8'sd1};
        run_frame(1, -1, 0);
    endtask

    task automatic test_backpressure();
        frame = {8'sd1, 8'sd9};
        run_frame(0, -1, 0);
        in_valid = 1'b1;
        in_data  = 8'd55;
        in_last  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            vectors++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
                out_max !== 8'd9 || out_idx !== 8'd1) begin
                errors++;
                $display("FAIL backpressure: rdy=%b v=%b max=%h idx=%0d required 0/1/09/1",
                         in_ready, out_valid, out_max, out_idx);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_result();
        out_ready = 1'b1;
        step();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_max !== 8'd9) begin
            errors++;
            $display("FAIL bp_release: v=%b rdy=%b max=%h required 0/1/09",
                     out_valid, in_ready, out_max);
        end
    endtask

    task automatic test_overflow();
        frame = {8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd50};
        run_frame(1, -1, 0);
        frame = {8'sd1, 8'sd2, 8'sd3, 8'sd4};
        run_frame(1, -1, 0);
        frame = {8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd9, 8'sd9, -8'sd5};
        run_frame(1, -1, 0);
        frame = {};
        for (int i = 0; i < 300; i++)
            frame.push_back(8'($urandom_range(0, 200)) - 8'sd100);
        frame[280] = 8'sd127;
        run_frame(1, -1, 0);
    endtask

    task automatic test_idle_gap();
        frame = {-8'sd7, -8'sd6, 8'sd3, 8'sd2};
        run_frame(1, 2, 4);
    endtask

    task automatic test_midframe_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'd100;
        in_last   = 1'b0;
        wait_accept();
        wait_accept();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        for (int c = 0; c < 2; c++) begin
            step();
            vectors++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_max !== 8'h00) begin
                errors++;
                $display("FAIL midframe_reset: v=%b rdy=%b max=%h required 0/0/00",
                         out_valid, in_ready, out_max);
            end
        end
        rst_n = 1'b1;
        frame = {8'sd7};
        run_frame(1, -1, 0);
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 6; f++) begin
            int n;
            n = $urandom_range(1, 8);
            frame = {};
            for (int i = 0; i < n; i++)
                frame.push_back(8'($urandom_range(0, 255)));
            run_frame(1, -1, 0);
        end
    endtask

    initial begin
        test_reset();
        test_signed_frames();
        test_backpressure();
        test_overflow();
        test_idle_gap();
        test_midframe_reset();
        test_back_to_back();
        vectors++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: %0d entries required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
